// File: rtl/cpu_pkg.sv
// Shared core constants: opcodes, register selects, fetch FSM encoding and fault codes.
// The executor FSMs import the same opcode and register constants.
package cpu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_ADD  = 4'h1;
  localparam opcode_t OP_SUB  = 4'h2;
  localparam opcode_t OP_AND  = 4'h3;
  localparam opcode_t OP_OR   = 4'h4;
  localparam opcode_t OP_XOR  = 4'h5;
  localparam opcode_t OP_MOV  = 4'h6;
  localparam opcode_t OP_JMP  = 4'h7;
  localparam opcode_t OP_HALT = 4'hF;

  localparam logic [2:0] REG_G0 = 3'd0;
  localparam logic [2:0] REG_P0 = 3'd1;
  localparam logic [2:0] REG_G1 = 3'd2;
  localparam logic [2:0] REG_G2 = 3'd3;
  localparam logic [2:0] REG_G3 = 3'd4;
  localparam logic [2:0] REG_P1 = 3'd5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  function automatic opcode_t opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/fetch_dispatch_ctrl_exec_timeout_ctr.sv
// Watchdog for the EXEC phase: counts EXEC cycles without a done strobe.
// expired_o fires combinationally in the cycle whose edge would bring the count to TIMEOUT.
module exec_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  assign expired_o = enable_i && !clear_i && (count_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// Instruction fetch/dispatch controller: owns the PC, fetches over req/ack,
// releases the executors for one instruction at a time and applies their pc_inc strobes.
module fetch_dispatch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] OP_VALID = 16'h00FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       ir,
  output logic              if_active,
  input  logic              pc_inc,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [2:0]        state_dbg
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              in_exec;
  logic              timeout_expired;
  opcode_t           op;

  assign in_exec = (state_q == ST_EXEC);
  assign op      = opcode_of(ir_q);

  exec_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!in_exec),
    .enable_i (in_exec && !exec_done),
    .expired_o(timeout_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (!OP_VALID[op]) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (pc_inc) pc_d = pc_q + 1'b1;
        // A done strobe in the last allowed cycle beats the watchdog.
        if (exec_done) begin
          state_d = run ? ST_FETCH : ST_IDLE;
        end else if (timeout_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign mem_rd     = (state_q == ST_FETCH);
  assign mem_addr   = mem_rd ? pc_q : '0;
  assign ir         = ir_q;
  assign if_active  = !in_exec;
  assign pc         = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// Bench for fetch_dispatch_ctrl: memory responder and executor models drive the DUT,
// a monitor checks fetch addresses and dispatched words against a PC/program model.
module tb_fetch_dispatch_ctrl;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        run;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        if_active;
  logic        pc_inc;
  logic        exec_done;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  state_dbg;

  fetch_dispatch_ctrl #(
    .ADDR_W(8),
    .TIMEOUT(15),
    .OP_VALID(16'h00FF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .if_active (if_active),
    .pc_inc    (pc_inc),
    .exec_done (exec_done),
    .pc        (pc),
    .halted    (halted),
    .fault     (fault),
    .fault_code(fault_code),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- shared bench state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [15:0] mem [256];
  int          mem_lat;     // -1 selects random 0..3 wait cycles
  bit          resp_en;
  int          exec_mode;   // 0 random, 1 MOV-like, 2 never done, 3 done at 15, 4 long incrementer
  bit          stray_en;
  logic [7:0]  model_pc;
  logic [7:0]  exp_addr_q[$];
  logic [15:0] exp_ir_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int req_cnt;
    int lat;
    req_cnt   = 0;
    lat       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) continue;
      if (mem_rd && !rst) begin
        if (req_cnt == 0) lat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        if (req_cnt == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
        end
        req_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        req_cnt   = 0;
      end
    end
  end

  // ---------------- executor model ----------------
  initial begin
    int c;
    int len;
    int n;
    bit incs[16];
    c = 0;
    len = 0;
    pc_inc = 1'b0;
    exec_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        c = 0;
        pc_inc = 1'b0;
        exec_done = 1'b0;
        continue;
      end
      if (!if_active) begin
        c++;
        if (c == 1) begin
          for (int i = 0; i < 16; i++) incs[i] = 1'b0;
          case (exec_mode)
            0: begin
              len = $urandom_range(1, 8);
              for (int i = 1; i <= len; i++) incs[i] = 1'($urandom_range(0, 1));
            end
            1: begin len = 4; incs[2] = 1'b1; end
            2: len = 0;
            3: begin len = 15; incs[1] = 1'b1; end
            default: begin
              len = 14;
              for (int i = 1; i <= 14; i++) incs[i] = 1'b1;
            end
          endcase
          n = 0;
          for (int i = 1; i < 16; i++) if (incs[i]) n++;
          model_pc = model_pc + 8'(n);
          if (exec_mode != 2) exp_addr_q.push_back(model_pc);
        end
        pc_inc    = (c < 16) ? incs[c] : 1'b0;
        exec_done = (len != 0) && (c == len);
      end else begin
        if (c != 0 && len != 0) check("exec_len", 32'(c), 32'(len));
        c = 0;
        pc_inc    = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        exec_done = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit         prev_ifa;
    logic [7:0] a;
    prev_ifa = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ifa = 1'b1;
        continue;
      end
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) begin
          check("fetch_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        end else begin
          check("fetch_addr", 32'(mem_addr), 32'(exp_addr_q[0]));
          if (mem_ack) begin
            a = exp_addr_q.pop_front();
            exp_ir_q.push_back(mem[a]);
          end
        end
      end
      if (!if_active && prev_ifa) begin
        if (exp_ir_q.size() == 0) check("dispatch_expected", 32'(exp_ir_q.size() != 0), 32'd1);
        else check("exec_ir", 32'(ir), 32'(exp_ir_q.pop_front()));
      end
      prev_ifa = if_active;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit run_v);
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    exp_addr_q.delete();
    exp_ir_q.delete();
    model_pc = '0;
    exp_addr_q.push_back(8'h00);
    @(negedge clk);
    rst = 1'b0;
    run = run_v;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic wait_halt_or_fault(input int budget);
    for (int i = 0; i < budget && !halted && !fault; i++) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  rd_tr, ia_tr;
    logic [15:0] ir3;
    logic [7:0]  pc7, addr7, last_addr;
    int          n;
    bit          prev_rd, wrapped;

    rst = 1'b1; run = 1'b0; resp_en = 1'b1; mem_lat = 0; exec_mode = 1; stray_en = 1'b0;
    model_pc = '0;

    // Reset values and single MOV trace with zero-wait memory
    fill_halt();
    mem[0] = 16'h6080;
    do_reset(1'b1);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_if_active", 32'(if_active), 32'h1);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_code", 32'(fault_code), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    ir3 = '0; pc7 = '0; addr7 = '0;
    for (int i = 0; i < 8; i++) begin
      rd_tr[i] = mem_rd;
      ia_tr[i] = if_active;
      if (i == 3) ir3 = ir;
      if (i == 7) begin pc7 = pc; addr7 = mem_addr; end
      @(negedge clk);
    end
    check("mov_rd_trace", 32'(rd_tr), 32'h82);
    check("mov_ifa_trace", 32'(ia_tr), 32'h87);
    check("mov_ir", 32'(ir3), 32'h6080);
    check("mov_pc", 32'(pc7), 32'h01);
    check("mov_next_addr", 32'(addr7), 32'h01);

    // HALT: frozen state, no further fetches
    wait_halt_or_fault(10);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h01);
    check("halt_ir", 32'(ir), 32'hF000);
    check("halt_if_active", 32'(if_active), 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd) n++;
      @(negedge clk);
    end
    check("halt_no_fetch", 32'(n), 32'h0);
    check("halt_pc_frozen", 32'(pc), 32'h01);
    rst = 1'b1;
    #1;
    check("halt_rst_clears", 32'(halted), 32'h0);

    // Delayed acknowledge: request held, ir only updates on the ack edge
    fill_halt();
    mem[0] = 16'h6123;
    mem_lat = 3;
    do_reset(1'b1);
    for (int i = 0; i < 10 && !mem_rd; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("wait_mem_rd", 32'(mem_rd), 32'h1);
      check("wait_mem_addr", 32'(mem_addr), 32'h0);
      check("wait_ir", 32'(ir), 32'h0);
      check("wait_if_active", 32'(if_active), 32'h1);
      @(negedge clk);
    end
    check("ack_cycle_ir", 32'(ir), 32'h0);
    @(negedge clk);
    check("after_ack_ir", 32'(ir), 32'h6123);
    wait_halt_or_fault(40);
    check("delay_halted", 32'(halted), 32'h1);

    // Illegal opcode
    fill_halt();
    mem[0] = 16'h9000;
    mem_lat = 0;
    do_reset(1'b1);
    wait_halt_or_fault(10);
    check("illegal_fault", 32'(fault), 32'h1);
    check("illegal_code", 32'(fault_code), 32'(FC_ILLEGAL));
    check("illegal_not_halted", 32'(halted), 32'h0);
    repeat (5) @(negedge clk);
    check("illegal_pc", 32'(pc), 32'h0);
    check("illegal_no_fetch", 32'(mem_rd), 32'h0);
    check("illegal_if_active", 32'(if_active), 32'h1);

    // Executor timeout: exactly 15 EXEC cycles
    fill_halt();
    mem[0] = 16'h6000;
    exec_mode = 2;
    do_reset(1'b1);
    n = 0;
    for (int i = 0; i < 60 && !fault; i++) begin
      if (!if_active) n++;
      @(negedge clk);
    end
    check("timeout_cycles", 32'(n), 32'd15);
    check("timeout_fault", 32'(fault), 32'h1);
    check("timeout_code", 32'(fault_code), 32'(FC_TIMEOUT));
    check("timeout_ir", 32'(ir), 32'h6000);

    // Done in the 15th cycle wins over the timeout
    mem[1] = 16'hF000;
    exec_mode = 3;
    do_reset(1'b1);
    wait_halt_or_fault(60);
    check("late_done_no_fault", 32'(fault), 32'h0);
    check("late_done_halted", 32'(halted), 32'h1);
    check("late_done_pc", 32'(pc), 32'h01);

    // PC wraps through 8'hFF, then reset in the middle of a fetch handshake
    for (int i = 0; i < 256; i++) mem[i] = 16'h6000;
    exec_mode = 4;
    mem_lat = 2;
    do_reset(1'b1);
    prev_rd = 1'b0; wrapped = 1'b0; last_addr = '0;
    for (int i = 0; i < 1000 && !wrapped; i++) begin
      @(negedge clk);
      if (mem_rd && !prev_rd) begin
        if (mem_addr < last_addr) wrapped = 1'b1;
        last_addr = mem_addr;
      end
      prev_rd = mem_rd;
    end
    check("wrap_seen", 32'(wrapped), 32'h1);
    check("wrap_addr", 32'(mem_addr), 32'd10);
    check("wrap_pc", 32'(pc), 32'd10);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midfetch_mem_rd", 32'(mem_rd), 32'h0);
    check("midfetch_mem_addr", 32'(mem_addr), 32'h0);
    check("midfetch_pc", 32'(pc), 32'h0);
    check("midfetch_if_active", 32'(if_active), 32'h1);
    resp_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hABCD;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_ack_ir", 32'(ir), 32'h0);
    check("stale_ack_mem_rd", 32'(mem_rd), 32'h0);
    check("stale_ack_state", 32'(state_dbg), 32'(ST_IDLE));
    mem_ack = 1'b0;
    resp_en = 1'b1;

    // run dropped during EXEC: finish, go IDLE, resume on run
    fill_halt();
    mem[0] = 16'h6080;
    exec_mode = 1;
    mem_lat = 0;
    do_reset(1'b1);
    for (int i = 0; i < 10 && if_active; i++) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 10 && !if_active; i++) @(negedge clk);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd) n++;
      @(negedge clk);
    end
    check("rundrop_no_fetch", 32'(n), 32'h0);
    check("rundrop_pc", 32'(pc), 32'h01);
    check("rundrop_state", 32'(state_dbg), 32'(ST_IDLE));
    run = 1'b1;
    wait_halt_or_fault(20);
    check("rundrop_resume_halt", 32'(halted), 32'h1);

    // Randomized program, latencies, executor lengths and stray strobes
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, 3'($urandom_range(0, 7)), 12'($urandom)};
    exec_mode = 0;
    mem_lat = -1;
    stray_en = 1'b1;
    do_reset(1'b1);
    repeat (1500) @(negedge clk);
    check("random_no_fault", 32'(fault), 32'h0);
    check("random_no_halt", 32'(halted), 32'h0);
    stray_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_dispatch_ctrl.md
Name: fetch_dispatch_ctrl

Overview:
Instruction fetch and dispatch controller for the microcontroller core. Owns the program counter. Fetches 16-bit instruction words over a req/ack memory handshake and presents them as the instruction word to all execution FSMs (MOV, ALU and others). Holds those FSMs in their idle state through if_active, then waits for their done pulse and applies their pc_inc requests.

Parameters:
ADDR_W, 8, program counter / instruction address width
TIMEOUT, 15, max EXEC cycles without exec_done before fault (1..255)
OP_VALID, 16'h00FF, bit n set = opcode n is implemented by some executor

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
run  in  1  level; permits fetching new instructions
mem_rd  out  1  fetch request
mem_addr  out  ADDR_W  fetch address (= pc while mem_rd)
mem_ack  in  1  fetch data valid this cycle
mem_rdata  in  16  instruction word
ir  out  16  latched instruction word (executor fullBitNum)
if_active  out  1  high = executors forced to idle state
pc_inc  in  1  OR of executor PC_inc strobes
exec_done  in  1  OR of executor done strobes
pc  out  ADDR_W  program counter
halted  out  1  HALT opcode executed
fault  out  1  illegal opcode or executor timeout
fault_code  out  2  00 none, 01 illegal opcode, 10 timeout

Behaviour:
- Reset values: pc=0, ir=0, mem_rd=0, mem_addr=0, if_active=1, halted=0, fault=0, fault_code=00, state IDLE, timeout count 0.
- States:
  - IDLE -> FETCH when run=1.
  - FETCH -> DECODE on the edge where mem_ack=1.
  - DECODE -> HALT / FAULT / EXEC.
  - EXEC -> FETCH or IDLE.
  - HALT and FAULT are terminal; only rst leaves them.
- FETCH:
  - mem_rd=1, mem_addr=pc, held stable until mem_ack.
  - ir <= mem_rdata on the mem_ack edge.
  - Zero-wait memory (ack in the first FETCH cycle) is legal. mem_ack outside FETCH is ignored.
- DECODE, one cycle, uses ir[15:12]:
  - 4'hF -> HALT, halted=1.
  - OP_VALID[op]=0 -> FAULT, code 01.
  - Otherwise -> EXEC.
- if_active:
  - 1 in every state except EXEC.
  - Deasserts in the first EXEC cycle, so executors leave their idle state on the edge ending that cycle.
- EXEC:
  - ir held constant; mem_rd=0.
  - Each cycle with pc_inc=1 -> pc <= pc+1, wrapping modulo 2^ADDR_W. A multi-cycle pc_inc level increments once per cycle.
  - pc_inc outside EXEC is ignored.
- Exit EXEC on exec_done=1: to FETCH if run=1, else to IDLE. The count resets on every EXEC entry.
- Timeout: counter increments each EXEC cycle without exec_done. When the count reaches TIMEOUT -> FAULT, code 10.
- Simultaneous events:
  - exec_done in the timeout cycle: done wins, no fault.
  - pc_inc together with exec_done: the increment is applied and the exit is taken.
- run deasserted during FETCH/DECODE/EXEC: the current instruction completes, then IDLE. run is only sampled in IDLE and at EXEC exit.
- In FAULT and HALT: if_active=1, pc and ir frozen, fault/halted held.
- rst mid-operation (any state, including mid-handshake) returns all outputs to reset values immediately. A pending mem_ack afterwards is ignored.
- Latency, MOV with zero-wait memory: FETCH 1, DECODE 1, EXEC 4 (executor st0..st3) -> 6 cycles per instruction.

Decomposition:
- Shared package cpu_pkg:
  - 4-bit opcode constants (OP_MOV=4'h6, OP_HALT=4'hF, others).
  - Register select codes (G0=0, P0=1, G1=2, G2=3, G3=4, P1=5).
  - Fetch state encoding and fault_code values.
  - The same opcode and register constants are used by the executor FSMs.
- One sub-module: exec_timeout_ctr.
  - Parameterized TIMEOUT.
  - Inputs clear/enable; output expired.

Test Plan:
- Reset, run=1, zero-wait memory, mem[0]=16'h6080 (MOV G1<-G0), executor model pulses pc_inc in EXEC cycle 2 and done in cycle 4 -> mem_rd at cycle 1, ir=16'h6080, if_active low 4 cycles, pc=1, next fetch at addr 1 on cycle 7.
- mem_ack delayed 3 cycles -> mem_rd and mem_addr stable for all 3 cycles, ir updates only on the ack edge, if_active stays 1.
- ir=16'hF000 -> halted=1 after DECODE; pc and ir frozen; no further mem_rd for 20 cycles; rst clears halted.
- Opcode 4'h9 with OP_VALID=16'h00FF -> fault=1, fault_code=01.
- Opcode 4'h6 with no exec_done -> fault code 10 after exactly 15 EXEC cycles.
- Variant: exec_done in cycle 15 -> no fault.
- pc=8'hFF with pc_inc -> pc=8'h00.
- rst asserted mid-FETCH -> mem_rd=0, pc=0 the same cycle.
- run dropped during EXEC -> IDLE after done, no new mem_rd.
